// File: rtl/data_mem_responder_if.sv
// Load/store request/response bundle between the MEM stage and the data-memory responder.
interface data_mem_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output mem_r_en, mem_w_en, addr, wdata, input rdata, ready);
    modport slave  (input mem_r_en, mem_w_en, addr, wdata, output rdata, ready);
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: latches one load/store in IDLE, waits WAIT_CYCLES,
// commits, then raises ready for one DONE cycle.
module data_mem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic      clk,
    input  logic      rst,
    data_mem_if.slave mem_s
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [31:0] BASE  = 32'(BASE_ADDR);
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             we_q, we_d;
    logic [31:0]      mem_q [DEPTH];

    logic             req;
    logic             ready_c;
    logic             mem_we;
    logic             in_range;
    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;

    assign req      = mem_s.mem_r_en | mem_s.mem_w_en;
    // Range test on the offset avoids overflow of BASE + 4*DEPTH.
    assign offset   = addr_q - BASE;
    assign in_range = (addr_q >= BASE) && (offset < SPAN);
    assign idx      = offset[IDX_W+1:2];

    assign mem_s.ready = ready_c;
    assign mem_s.rdata = rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = ~req;
                if (req) begin
                    addr_d  = mem_s.addr;
                    wdata_d = mem_s.wdata;
                    we_d    = mem_s.mem_w_en;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    if (we_q) begin
                        mem_we = in_range;
                    end else begin
                        rdata_d = in_range ? mem_q[idx] : 32'h0;
                    end
                end
            end
            DONE: begin
                ready_c = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array is not reset; reset only clears the control path.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a transaction-level reference model.
module tb_data_mem_responder;
    localparam int W     = 4;
    localparam int DEPTH = 64;
    localparam int BASE  = 1024;

    logic clk = 1'b0;
    logic rst;
    data_mem_if bus ();

    data_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .mem_s (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an access occupies cycles k=0..W with ready low, k=W+1 is the ready cycle.
    logic [31:0] mmem [DEPTH];
    int          k = -1;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, m_rdata = 32'h0;
    logic        m_req, m_exp_ready;

    function automatic logic m_in(input logic [31:0] a);
        return (a >= 32'(BASE)) && (a < 32'(BASE + 4 * DEPTH));
    endfunction

    always @(negedge clk) begin
        m_req = bus.mem_r_en | bus.mem_w_en;
        if (rst) begin
            k = -1;
            m_rdata = 32'h0;
            m_exp_ready = ~m_req;
        end else if (k < 0) begin
            m_exp_ready = ~m_req;
        end else if (k <= W) begin
            m_exp_ready = 1'b0;
        end else begin
            m_exp_ready = 1'b1;
        end
        chk("model_ready", 32'(bus.ready), 32'(m_exp_ready));
        chk("model_rdata", bus.rdata, m_rdata);
        if (!rst) begin
            if (k < 0) begin
                if (m_req) begin
                    m_we    = bus.mem_w_en;
                    m_addr  = bus.addr;
                    m_wdata = bus.wdata;
                    k = 1;
                end
            end else if (k <= W) begin
                if (k == W) begin
                    if (m_we) begin
                        if (m_in(m_addr)) mmem[(m_addr - 32'(BASE)) >> 2] = m_wdata;
                    end else begin
                        m_rdata = m_in(m_addr) ? mmem[(m_addr - 32'(BASE)) >> 2] : 32'h0;
                    end
                end
                k++;
            end else begin
                k = -1;
            end
        end
    end

    task automatic set_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.mem_r_en = r;
        bus.mem_w_en = w;
        bus.addr     = a;
        bus.wdata    = d;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (n) @(negedge clk);
    endtask

    // Issue one access; optionally drop the request after drop_at low cycles.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int drop_at, output logic [31:0] rd, output int lows);
        logic got;
        got  = 1'b0;
        lows = 0;
        rd   = 32'h0;
        @(posedge clk); #1;
        set_req(r, w, a, d);
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) begin
                rd  = bus.rdata;
                got = 1'b1;
            end else begin
                lows++;
                if (lows == drop_at) begin
                    @(posedge clk); #1;
                    set_req(1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL access_timeout: addr %h never returned ready", a);
        end
    endtask

    logic [31:0] rd, prev;
    int          lows;

    initial begin
        for (int i = 0; i < DEPTH; i++) mmem[i] = 32'h0;
        rst = 1'b1;
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(bus.ready), 32'h1);
        chk("reset_rdata", bus.rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        idle(2);

        // Store then load the first word
        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 0, rd, lows);
        chk("store_latency", 32'(lows), 32'd5);
        idle(2);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 0, rd, lows);
        chk("load_latency", 32'(lows), 32'd5);
        chk("load_1024", rd, 32'hDEADBEEF);
        idle(1);

        // Low address bits ignored; out-of-range accesses
        access(1'b0, 1'b1, 32'd1027, 32'h12345678, 0, rd, lows);
        idle(1);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 0, rd, lows);
        chk("load_lowbits", rd, 32'h12345678);
        idle(1);
        access(1'b1, 1'b0, 32'd1280, 32'h0, 0, rd, lows);
        chk("load_word64", rd, 32'h0);
        idle(1);
        access(1'b0, 1'b1, 32'd1276, 32'h00006363, 0, rd, lows);
        idle(1);
        access(1'b1, 1'b0, 32'd1276, 32'h0, 0, rd, lows);
        chk("load_word63", rd, 32'h00006363);
        idle(1);
        access(1'b1, 1'b0, 32'd1023, 32'h0, 0, rd, lows);
        chk("load_1023", rd, 32'h0);
        idle(1);
        access(1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 0, rd, lows);
        idle(1);
        access(1'b1, 1'b0, 32'h0, 32'h0, 0, rd, lows);
        chk("load_addr0", rd, 32'h0);
        idle(1);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 0, rd, lows);
        chk("word0_kept", rd, 32'h12345678);
        idle(1);

        // Both enables set: write wins, rdata untouched
        prev = bus.rdata;
        access(1'b1, 1'b1, 32'd1028, 32'hA5A5A5A5, 0, rd, lows);
        chk("rw_rdata_hold", rd, prev);
        idle(1);
        access(1'b1, 1'b0, 32'd1028, 32'h0, 0, rd, lows);
        chk("rw_was_write", rd, 32'hA5A5A5A5);
        idle(1);

        // Back-to-back store then load with no bubble beyond one IDLE cycle
        access(1'b0, 1'b1, 32'd1032, 32'hCAFE0004, 0, rd, lows);
        chk("b2b_store_lows", 32'(lows), 32'd5);
        access(1'b1, 1'b0, 32'd1032, 32'h0, 0, rd, lows);
        chk("b2b_load_lows", 32'(lows), 32'd5);
        chk("b2b_load_data", rd, 32'hCAFE0004);
        idle(1);

        // Reset mid-access discards the pending write
        access(1'b0, 1'b1, 32'd1036, 32'h00000099, 0, rd, lows);
        idle(1);
        @(posedge clk); #1 set_req(1'b0, 1'b1, 32'd1036, 32'h00000001);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_cnt2_ready", 32'(bus.ready), 32'h1);
        chk("rst_cnt2_rdata", bus.rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        idle(1);
        access(1'b1, 1'b0, 32'd1036, 32'h0, 0, rd, lows);
        chk("rst_cnt2_word3", rd, 32'h00000099);
        idle(1);
        @(posedge clk); #1 set_req(1'b0, 1'b1, 32'd1036, 32'h00000001);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.ready), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        idle(1);
        access(1'b1, 1'b0, 32'd1036, 32'h0, 0, rd, lows);
        chk("rst_cnt3_word3", rd, 32'h00000099);

        // Quiet bus, then a request dropped during BUSY
        idle(1);
        prev = bus.rdata;
        idle(10);
        chk("idle_ready", 32'(bus.ready), 32'h1);
        chk("idle_rdata", bus.rdata, prev);
        access(1'b1, 1'b0, 32'd1032, 32'h0, 2, rd, lows);
        chk("drop_lows", 32'(lows), 32'd5);
        chk("drop_data", rd, 32'hCAFE0004);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
